tcp_tx_arbiter: RTL and testbench

//  Shares the single TCP TX engine between N_REQ segment requesters (server/client control FSMs, ACK generator, data path).

---
 rtl/tcp_tx_arb_pkg.sv | 21 ++
 rtl/tcp_rr_picker.sv | 51 +++++
 rtl/tcp_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_tcp_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_tx_arb_pkg.sv
// Shared types and default constants for the TCP TX engine arbiter.
package tcp_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } tcp_tx_arb_state_t;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_TIMEOUT   = 1024;
    localparam int DEF_IFG       = 2;
    localparam int DEF_ERR_CNT_W = 8;

    // Bits needed for a down-counter loaded with (max_val - 1); never narrower than 1.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/tcp_rr_picker.sv
// Combinational winner selection: lowest-index urgent request first, otherwise
// the first valid request found walking upward (with wrap) from rr_ptr.
module tcp_rr_picker
    import tcp_tx_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] vld,
    input  logic [N_REQ-1:0] urgent,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_urgent,
    output logic             any_vld
);

    logic [N_REQ-1:0] urg_vld;
    logic             urg_found;
    logic [IDX_W-1:0] urg_idx;
    logic [IDX_W-1:0] rr_idx;

    always_comb begin
        int j;
        j         = 0;
        urg_vld   = vld & urgent;
        urg_found = 1'b0;
        urg_idx   = '0;
        rr_idx    = '0;

        // Walk downward so the last hit (the lowest index) wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (urg_vld[IDX_W'(i)]) begin
                urg_found = 1'b1;
                urg_idx   = IDX_W'(i);
            end
        end

        // Same trick for round-robin: the last hit is the closest to rr_ptr.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % N_REQ;
            if (vld[IDX_W'(j)]) begin
                rr_idx = IDX_W'(j);
            end
        end

        win_idx    = urg_found ? urg_idx : rr_idx;
        win_urgent = urg_found;
        any_vld    = |vld;
    end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Shares one TCP TX engine among N_REQ requesters: urgent-first, else round-robin,
// holding the grant across accept/done with a timeout and an inter-frame gap.
module tcp_tx_arbiter
    import tcp_tx_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int IFG       = DEF_IFG,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_vld,
    input  logic [N_REQ-1:0]          req_urgent,
    input  logic                      flush_in,
    input  logic                      tx_eng_acc_in,
    input  logic                      tx_done_in,
    output logic                      tx_req,
    output logic [$clog2(N_REQ)-1:0]  tx_sel,
    output logic [N_REQ-1:0]          req_ack,
    output logic [N_REQ-1:0]          req_done,
    output logic [N_REQ-1:0]          req_err,
    output logic                      busy,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    output tcp_tx_arb_state_t         dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = cnt_width(TIMEOUT);
    localparam int GAP_W = cnt_width(IFG);
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((IFG > 0) ? IFG - 1 : 0);

    // Engine handshake: tx_req/tx_sel are held stable until the cycle tx_eng_acc_in
    // is seen high (transfer accepted), then the grant stays owned until tx_done_in,
    // timeout or flush; tx_done_in is only meaningful after acceptance.

    tcp_tx_arb_state_t state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic                 urg_q, urg_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 tx_req_q, tx_req_d;
    logic                 busy_q, busy_d;
    logic [N_REQ-1:0]     req_ack_q, req_ack_d;
    logic [N_REQ-1:0]     req_done_q, req_done_d;
    logic [N_REQ-1:0]     req_err_q, req_err_d;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_urgent;
    logic                 pick_any;
    logic [N_REQ-1:0]     sel_oh;
    logic                 xfer_end;

    tcp_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .vld        (req_vld),
        .urgent     (req_urgent),
        .rr_ptr     (rr_ptr_q),
        .win_idx    (pick_idx),
        .win_urgent (pick_urgent),
        .any_vld    (pick_any)
    );

    assign sel_oh = N_REQ'(1) << sel_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        urg_d      = urg_q;
        rr_ptr_d   = rr_ptr_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        err_cnt_d  = err_cnt_q;
        req_ack_d  = '0;
        req_done_d = '0;
        req_err_d  = '0;
        xfer_end   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!flush_in && pick_any) begin
                    state_d = REQ;
                    sel_d   = pick_idx;
                    urg_d   = pick_urgent;
                end
            end
            REQ: begin
                // Withdraw outranks a same-cycle accept: the requester no longer owns a segment.
                if (flush_in || ((req_vld & sel_oh) == '0)) begin
                    state_d = IDLE;
                end else if (tx_eng_acc_in) begin
                    state_d   = BUSY;
                    req_ack_d = sel_oh;
                    timer_d   = TMR_INIT;
                end
            end
            BUSY: begin
                if (flush_in) begin
                    state_d   = IDLE;
                    req_err_d = sel_oh;
                end else if (tx_done_in) begin
                    req_done_d = sel_oh;
                    xfer_end   = 1'b1;
                end else if (timer_q == '0) begin
                    req_err_d = sel_oh;
                    xfer_end  = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only a completed or timed-out non-urgent grant advances the rotation.
        if (xfer_end) begin
            state_d = (IFG > 0) ? GAP : IDLE;
            gap_d   = GAP_INIT;
            if (!urg_q) begin
                rr_ptr_d = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
            end
        end

        tx_req_d = (state_d == REQ);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            urg_q      <= 1'b0;
            rr_ptr_q   <= '0;
            timer_q    <= '0;
            gap_q      <= '0;
            err_cnt_q  <= '0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            req_ack_q  <= '0;
            req_done_q <= '0;
            req_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            urg_q      <= urg_d;
            rr_ptr_q   <= rr_ptr_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            err_cnt_q  <= err_cnt_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            req_ack_q  <= req_ack_d;
            req_done_q <= req_done_d;
            req_err_q  <= req_err_d;
        end
    end

    assign tx_req    = tx_req_q;
    assign tx_sel    = sel_q;
    assign req_ack   = req_ack_q;
    assign req_done  = req_done_q;
    assign req_err   = req_err_q;
    assign busy      = busy_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Bench for tcp_tx_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level reference model built on absolute cycle stamps.
module tb_tcp_tx_arbiter;
    import tcp_tx_arb_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 1024;
    localparam int IFG = 2;
    localparam int ECW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_vld       = '0;
    logic [N-1:0]   req_urgent    = '0;
    logic           flush_in      = 1'b0;
    logic           tx_eng_acc_in = 1'b0;
    logic           tx_done_in    = 1'b0;
    logic           tx_req;
    logic [1:0]     tx_sel;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   req_done;
    logic [N-1:0]   req_err;
    logic           busy;
    logic [ECW-1:0] err_cnt;
    tcp_tx_arb_state_t dbg_state;

    tcp_tx_arbiter #(
        .N_REQ     (N),
        .TIMEOUT   (TMO),
        .IFG       (IFG),
        .ERR_CNT_W (ECW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_vld       (req_vld),
        .req_urgent    (req_urgent),
        .flush_in      (flush_in),
        .tx_eng_acc_in (tx_eng_acc_in),
        .tx_done_in    (tx_done_in),
        .tx_req        (tx_req),
        .tx_sel        (tx_sel),
        .req_ack       (req_ack),
        .req_done      (req_done),
        .req_err       (req_err),
        .busy          (busy),
        .err_cnt       (err_cnt),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r = N'(1) << i;
        return r;
    endfunction

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // ---------------- reference model ----------------
    // One transfer is tracked as: granted (offered to engine) -> in flight (accepted at
    // m_acc_cyc) -> finished; new grants are allowed from cycle m_free_at onward.
    bit           m_granted, m_in_flight, m_urg;
    int           m_owner, m_acc_cyc, m_free_at, m_rr, m_errs;
    logic [N-1:0] e_ack, e_done, e_err;

    function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] u,
                                input int rr, output bit is_urg);
        is_urg = 1'b0;
        for (int i = 0; i < N; i++)
            if (bit_at(v & u, i)) begin
                is_urg = 1'b1;
                return i;
            end
        for (int k = 0; k < N; k++)
            if (bit_at(v, (rr + k) % N)) return (rr + k) % N;
        return 0;
    endfunction

    task automatic reset_model();
        m_granted = 0; m_in_flight = 0; m_urg = 0;
        m_owner = 0; m_acc_cyc = 0; m_free_at = 0; m_rr = 0; m_errs = 0;
        e_ack = '0; e_done = '0; e_err = '0;
    endtask

    task automatic model_step();
        bit u;
        e_ack = '0; e_done = '0; e_err = '0;
        if (m_in_flight) begin
            if (flush_in) begin
                e_err = onehot(m_owner);
                m_in_flight = 0;
                m_free_at = cyc + 1;
            end else if (tx_done_in || (cyc - m_acc_cyc >= TMO)) begin
                if (tx_done_in) e_done = onehot(m_owner);
                else begin
                    e_err = onehot(m_owner);
                    if (m_errs < (1 << ECW) - 1) m_errs++;
                end
                m_in_flight = 0;
                m_free_at = cyc + IFG + 1;
                if (!m_urg) m_rr = (m_owner + 1) % N;
            end
        end else if (m_granted) begin
            if (flush_in || !bit_at(req_vld, m_owner)) begin
                m_granted = 0;
                m_free_at = cyc + 1;
            end else if (tx_eng_acc_in) begin
                e_ack = onehot(m_owner);
                m_granted = 0;
                m_in_flight = 1;
                m_acc_cyc = cyc;
            end
        end else if (cyc >= m_free_at && !flush_in && req_vld != '0) begin
            m_owner = pick(req_vld, req_urgent, m_rr, u);
            m_urg = u;
            m_granted = 1;
        end
    endtask

    task automatic compare();
        bit exp_busy;
        exp_busy = m_granted || m_in_flight || (cyc + 1 < m_free_at);
        chk("tx_req", tx_req, m_granted);
        if (m_granted) chk("tx_sel", tx_sel, m_owner);
        chk("req_ack", req_ack, e_ack);
        chk("req_done", req_done, e_done);
        chk("req_err", req_err, e_err);
        chk("busy", busy, exp_busy);
        chk("dbg_state", dbg_state != IDLE, exp_busy);
        chk("err_cnt", err_cnt, m_errs);
        chk("pulse_onehot", $countones(req_ack | req_done | req_err) <= 1, 1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_tx_req"}, tx_req, 0);
        chk({tag, "_tx_sel"}, tx_sel, 0);
        chk({tag, "_pulses"}, req_ack | req_done | req_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    task automatic wait_grant(input int limit, output int idle);
        idle = 0;
        while (!tx_req && idle < limit) begin
            step();
            if (!tx_req) idle++;
        end
        chk("grant_seen", tx_req, 1);
    endtask

    task automatic serve(input string tag, input int exp_sel, output int idle);
        wait_grant(64, idle);
        chk({tag, "_sel"}, tx_sel, exp_sel);
        tx_eng_acc_in = 1'b1; step(); tx_eng_acc_in = 1'b0;
        chk({tag, "_ack"}, req_ack, onehot(exp_sel));
        tx_done_in = 1'b1; step(); tx_done_in = 1'b0;
        chk({tag, "_done"}, req_done, onehot(exp_sel));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idle;
        int k;
        logic [N-1:0] v;
        reset_model();

        repeat (2) @(posedge clk);
        #1 check_quiet("reset");
        #3 rst = 1'b1;

        // Round-robin over all four, immediate accept/done.
        req_vld = 4'b1111;
        for (int g = 0; g < 5; g++) exp_q.push_back(2'(g % N));
        for (int g = 0; g < 5; g++) begin
            serve("rr_all", int'(exp_q.pop_front()), idle);
            if (g == 0) chk("first_latency", idle, 0);
            else        chk("ifg_idle", idle, IFG);
        end

        // Urgent beats round-robin and leaves rr_ptr alone.
        req_vld = 4'b0010;
        serve("rr_to2", 1, idle);
        req_vld = 4'b1110; req_urgent = 4'b1000;
        serve("urgent3", 3, idle);
        req_vld = 4'b0110; req_urgent = 4'b0000;
        serve("after_urg", 2, idle);
        req_vld = 4'b1111;
        serve("rr_ptr3", 3, idle);

        // Timeout on grant 1.
        req_vld = 4'b0010;
        wait_grant(64, idle);
        chk("tmo_sel", tx_sel, 1);
        tx_eng_acc_in = 1'b1; step(); tx_eng_acc_in = 1'b0;
        k = 0;
        while (req_err == '0 && k < TMO + 50) begin
            step();
            k++;
        end
        chk("tmo_latency", k, TMO);
        chk("tmo_err", req_err, 4'b0010);
        chk("tmo_cnt", err_cnt, 1);
        wait_grant(64, idle);
        chk("tmo_freed", idle, IFG);

        // Done in the exact expiry cycle.
        chk("exp_sel", tx_sel, 1);
        tx_eng_acc_in = 1'b1; step(); tx_eng_acc_in = 1'b0;
        repeat (TMO - 1) step();
        tx_done_in = 1'b1; step(); tx_done_in = 1'b0;
        chk("exp_done", req_done, 4'b0010);
        chk("exp_no_err", req_err, 4'b0000);
        chk("exp_cnt", err_cnt, 1);

        // Flush during BUSY, then during REQ.
        req_vld = 4'b0100;
        wait_grant(64, idle);
        chk("fl_sel", tx_sel, 2);
        tx_eng_acc_in = 1'b1; step(); tx_eng_acc_in = 1'b0;
        repeat (3) step();
        flush_in = 1'b1; step();
        chk("fl_busy_err", req_err, 4'b0100);
        chk("fl_busy_cnt", err_cnt, 1);
        chk("fl_busy_idle", busy, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_block", tx_req, 0);
        end
        flush_in = 1'b0; step();
        chk("fl_release", tx_req, 1);
        chk("fl_release_sel", tx_sel, 2);
        flush_in = 1'b1; tx_eng_acc_in = 1'b1; step();
        flush_in = 1'b0; tx_eng_acc_in = 1'b0;
        chk("fl_req_noack", req_ack, 4'b0000);
        chk("fl_req_drop", tx_req, 0);

        // Asynchronous reset in the middle of BUSY.
        req_vld = 4'b0001;
        wait_grant(64, idle);
        tx_eng_acc_in = 1'b1; step(); tx_eng_acc_in = 1'b0;
        step();
        chk("pre_rst_busy", busy, 1);
        #3 rst = 1'b0;
        #1 check_quiet("async_rst");
        reset_model();
        repeat (2) @(posedge clk);
        #1 check_quiet("in_rst");
        #2 rst = 1'b1;
        step();
        chk("post_rst_req", tx_req, 1);
        chk("post_rst_sel", tx_sel, 0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            v = req_vld;
            for (int i = 0; i < N; i++) begin
                if (bit_at(req_ack, i) && $urandom_range(0, 1) == 1) v = v & ~onehot(i);
                else if (!bit_at(v, i) && $urandom_range(0, 3) == 0) v = v | onehot(i);
                else if (bit_at(v, i) && $urandom_range(0, 63) == 0) v = v & ~onehot(i);
            end
            req_vld = v;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) v[i] = 1'b1; else v[i] = 1'b0;
            req_urgent    = v;
            flush_in      = ($urandom_range(0, 49) == 0);
            tx_eng_acc_in = tx_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
            tx_done_in    = m_in_flight ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
